// File: rtl/voice_sequencer_if.sv
// Bundle between the voice sequencer, the voice register file, the wavetable ROM and soundgen2.
// The master modport is the sequencer's view; the slave modport is everything around it.
interface voice_sequencer_if #(
    parameter int unsigned IDXW = 3
);
    logic            tick48k;
    logic [IDXW-1:0] voice_idx;
    logic            voice_active;
    logic [15:0]     voice_phase_inc;
    logic [17:0]     voice_volume;
    logic [17:0]     voice_velocity;
    logic [8:0]      wt_addr;
    logic [9:0]      wt_data;
    logic [9:0]      wavetable_r;
    logic            wavetable_r_valid;
    logic [9:0]      wavetable_l;
    logic            wavetable_l_valid;
    logic [17:0]     volume_adsr;
    logic [17:0]     velocity;
    logic            sg_tick;
    logic            busy;
    logic            overrun;
    logic            overrun_clr;

    modport master (
        input  tick48k, voice_active, voice_phase_inc, voice_volume, voice_velocity,
               wt_data, overrun_clr,
        output voice_idx, wt_addr, wavetable_r, wavetable_r_valid, wavetable_l,
               wavetable_l_valid, volume_adsr, velocity, sg_tick, busy, overrun
    );

    modport slave (
        output tick48k, voice_active, voice_phase_inc, voice_volume, voice_velocity,
               wt_data, overrun_clr,
        input  voice_idx, wt_addr, wavetable_r, wavetable_r_valid, wavetable_l,
               wavetable_l_valid, volume_adsr, velocity, sg_tick, busy, overrun
    );
endinterface

// File: rtl/voice_sequencer.sv
// Per-frame scheduler: on each tick48k, walks the voices, fetches right/left wavetable
// samples for active voices, strobes them to soundgen2 and advances the phase accumulators.
module voice_sequencer #(
    parameter int unsigned NVOICE = 8,
    parameter int unsigned IDXW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    voice_sequencer_if.master  bus
);
    localparam int unsigned PHW = 16;
    localparam int unsigned SW  = 10;
    localparam int unsigned VW  = 18;
    localparam int unsigned AW  = 9;
    localparam logic [SW-1:0] MIDSCALE = SW'(128);

    typedef enum logic [2:0] {
        IDLE, FETCH, RD_R, RD_L, EMIT_R, EMIT_L, DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   vcnt;
    logic [PHW-1:0]    phase [NVOICE];
    logic [PHW-1:0]    inc_q;
    logic              last_voice;
    logic              in_voice_next;
    logic [AW-1:0]     wt_addr_next;
    logic [PHW-1:0]    phase_cur;

    assign last_voice    = (vcnt == IDXW'(NVOICE - 1));
    assign phase_cur     = phase[vcnt];
    assign bus.voice_idx = vcnt;

    // Next state plus next values of the registered outputs that depend on it
    always_comb begin
        state_next    = state;
        in_voice_next = 1'b0;
        wt_addr_next  = '0;
        case (state)
            IDLE:    if (bus.tick48k) state_next = FETCH;
            FETCH: begin
                if (bus.voice_active) state_next = RD_R;
                else if (last_voice)  state_next = DONE;
                else                  state_next = FETCH;
            end
            RD_R:    state_next = RD_L;
            RD_L:    state_next = EMIT_R;
            EMIT_R:  state_next = EMIT_L;
            EMIT_L:  state_next = last_voice ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        in_voice_next = (state_next == RD_R) || (state_next == RD_L) ||
                        (state_next == EMIT_R) || (state_next == EMIT_L);
        if (state_next == RD_R)      wt_addr_next = {1'b0, phase_cur[PHW-1 -: 8]};
        else if (state_next == RD_L) wt_addr_next = {1'b1, phase_cur[PHW-1 -: 8]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            vcnt                  <= '0;
            inc_q                 <= '0;
            for (int unsigned i = 0; i < NVOICE; i++) phase[i] <= '0;
            bus.wt_addr           <= '0;
            bus.wavetable_r       <= MIDSCALE;
            bus.wavetable_l       <= MIDSCALE;
            bus.wavetable_r_valid <= 1'b0;
            bus.wavetable_l_valid <= 1'b0;
            bus.volume_adsr       <= '0;
            bus.velocity          <= '0;
            bus.sg_tick           <= 1'b0;
            bus.busy              <= 1'b0;
            bus.overrun           <= 1'b0;
        end else begin
            state <= state_next;

            if (state == IDLE)            vcnt <= '0;
            else if (state_next == FETCH) vcnt <= vcnt + IDXW'(1);

            // A silent voice restarts at phase 0 on its next note-on
            if (state == FETCH) begin
                if (bus.voice_active) inc_q <= bus.voice_phase_inc;
                else                  phase[vcnt] <= '0;
            end
            if (state == EMIT_L) phase[vcnt] <= phase_cur + inc_q;

            bus.wt_addr <= wt_addr_next;

            // ROM data for the address presented last cycle arrives now
            bus.wavetable_r_valid <= (state == RD_L);
            if (state == RD_L) bus.wavetable_r <= bus.wt_data;
            bus.wavetable_l_valid <= (state == EMIT_R);
            if (state == EMIT_R) bus.wavetable_l <= bus.wt_data;

            if (in_voice_next) begin
                if (state == FETCH) begin
                    bus.volume_adsr <= VW'(bus.voice_volume);
                    bus.velocity    <= VW'(bus.voice_velocity);
                end
            end else begin
                bus.volume_adsr <= '0;
                bus.velocity    <= '0;
            end

            bus.sg_tick <= (state_next == DONE);
            bus.busy    <= (state_next != IDLE);

            // A tick landing in any busy state is dropped and flagged; set beats clear
            if (bus.tick48k && (state != IDLE)) bus.overrun <= 1'b1;
            else if (bus.overrun_clr)           bus.overrun <= 1'b0;
        end
    end
endmodule

// File: doc/voice_sequencer.md
# voice_sequencer

Per-frame scheduler that time-multiplexes the shared `soundgen2` mixing datapath across NVOICE synthesizer voices. On each `tick48k`, it walks the voice register file and, for every active voice, fetches a right and a left wavetable sample from a synchronous ROM. It presents each sample to `soundgen2` with a valid strobe, holding that voice's ADSR volume and velocity alongside. After the last voice it emits a one-cycle frame-latch tick to `soundgen2` and advances each voice's phase accumulator. It sits between the MIDI voice allocator (register file) and `soundgen2`.

## Interface
Parameters
- NVOICE, 8, number of voices; power of two, 2..32
- IDXW, 3, voice index width, equals log2(NVOICE)

Ports
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tick48k  in  1  one-cycle frame start strobe
- voice_idx  out  IDXW  voice register file read address
- voice_active  in  1  voice gate for voice_idx; combinational, same cycle
- voice_phase_inc  in  16  phase increment per frame for voice_idx
- voice_volume  in  18  ADSR volume for voice_idx
- voice_velocity  in  18  velocity for voice_idx
- wt_addr  out  9  ROM address; bit 8 selects table (0=right, 1=left), bits 7:0 index
- wt_data  in  10  ROM data; valid the cycle after wt_addr is presented
- wavetable_r  out  10  right sample to soundgen2
- wavetable_r_valid  out  1  right sample strobe
- wavetable_l  out  10  left sample to soundgen2
- wavetable_l_valid  out  1  left sample strobe
- volume_adsr  out  18  volume to soundgen2
- velocity  out  18  velocity to soundgen2
- sg_tick  out  1  frame latch strobe to soundgen2
- busy  out  1  high while a frame is being sequenced
- overrun  out  1  sticky: tick48k arrived while busy
- overrun_clr  in  1  clears overrun

## Operation
- Internal state: phase[NVOICE], 16 bits each. The current voice counter drives voice_idx.
- FSM states: IDLE, FETCH, RD_R, RD_L, EMIT_R, EMIT_L, DONE.
- IDLE: tick48k -> FETCH with voice counter = 0. busy = 0 only in IDLE.
- FETCH: sample voice_* at voice counter.
  - If voice_active = 1: latch phase_inc, volume and velocity, then go to RD_R.
  - If voice_active = 0: clear phase[v] to 0 (the next note-on starts at phase 0), then advance.
- RD_R: wt_addr = {1'b0, phase[v][15:8]}.
- RD_L: wt_addr = {1'b1, phase[v][15:8]}. Register wt_data into wavetable_r and set r_valid for the next cycle.
- EMIT_R: wavetable_r_valid = 1. Register wt_data into wavetable_l and set l_valid for the next cycle.
- EMIT_L: wavetable_l_valid = 1. phase[v] <= phase[v] + phase_inc, modulo 2^16 (wrap, no saturation). Then advance.
- Advance: if v == NVOICE-1, go to DONE; else v+1 and go to FETCH.
- DONE: sg_tick = 1 for exactly one cycle, then go to IDLE.
- volume_adsr and velocity:
  - Registered, driven from RD_R through EMIT_L of an active voice.
  - Forced to 0 in all other states.
- wavetable_r and wavetable_l hold their last value. Both are 10'd128 (midscale) out of reset.
- wt_addr = 0 in states other than RD_R and RD_L.
- overrun: set by tick48k in any non-IDLE state, including DONE; that tick is dropped. overrun_clr clears it. If set and clear arrive in the same cycle, set wins.
- Reset (any state, including mid-frame):
  - All outputs are 0, except wavetable_r and wavetable_l, which are 10'd128.
  - phase[] = 0, state = IDLE.
  - No sg_tick is issued for an aborted frame.

## Timing
- Active voice: 5 cycles (FETCH..EMIT_L). Inactive voice: 1 cycle (FETCH).
- Frame length from the tick48k cycle to sg_tick: 1 + NVOICE + 4·(active count) + 1 cycles, counted as the IDLE cycle, the FETCH cycles, the extra cycles per active voice, and DONE.
- wavetable_r_valid is always followed by wavetable_l_valid on the next cycle. Strobes never overlap.
- Consecutive voices have a gap of at least one cycle (FETCH) between l_valid and the next r_valid.
- Maximum frame with NVOICE=8 is 42 cycles, which fits well inside a 2000-cycle tick48k period.
- ROM latency is exactly 1 cycle; no handshake or backpressure.

## Test plan
- Reset release, no tick: all strobes 0, wavetable_r/l = 128, busy = 0, overrun = 0.
- Voice 2 only active, phase_inc = 16'h0100, ROM returns addr[7:0] + 10·addr[8]:
  - Frame 1: r = 0, l = 10.
  - Frame 2: r = 1, l = 11.
  - r_valid and l_valid are adjacent.
  - volume and velocity equal the file values (18'h01010, 18'h1ffff) during the voice window only.
  - sg_tick arrives 14 cycles after the tick48k cycle.
- Phase wrap: phase_inc = 16'hFFFF over 2 frames -> phase wraps to 16'hFFFE, ROM index 8'hFF.
- All 8 voices active -> 8 r/l strobe pairs in voice order, then sg_tick at cycle 42.
- Deactivate voice 2, then reactivate -> the first sample after reactivation reads index 0.
- tick48k asserted mid-frame and in the DONE cycle:
  - overrun = 1 and no new frame starts.
  - overrun_clr drops overrun.
  - Set and clear in the same cycle keep overrun = 1.
- Reset asserted in EMIT_R -> outputs return to reset values immediately; no sg_tick; the next frame starts with all phases at 0.
